// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot to binary sequencer: default sizes,
// the "no line" code and the FSM state encoding.
package onehot_pkg;

    localparam int N_LINES = 20;
    localparam int CODE_W  = 5;

    localparam logic [CODE_W-1:0] NONE_CODE = 5'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_lsb_find.sv
// Combinational lowest-set-bit finder: returns the index of the lowest set bit
// of vec and whether any bit is set at all.
module onehot_lsb_find #(
    parameter int W     = 20,
    parameter int IDX_W = 5
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one to win
    always_comb begin
        idx = {IDX_W{1'b0}};
        any = |vec;
        for (int i = W - 1; i >= 0; i--) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/onehot_to_binary_sequencer.sv
// Turns a multi-hot request vector into a stream of binary line codes (line k -> k+1),
// lowest line first, one per valid/ready handshake. Optional macro ONEHOT_EMPTY_CODE_EN
// makes an all-zero load deliver a single code-0 beat instead of an immediate done.
module onehot_to_binary_sequencer #(
    parameter int N_LINES = onehot_pkg::N_LINES,
    parameter int CODE_W  = onehot_pkg::CODE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] req_vec,
    input  logic               req_load,
    output logic               load_ready,
    output logic [CODE_W-1:0]  code_out,
    output logic               code_valid,
    input  logic               code_ready,
    output logic [CODE_W-1:0]  remaining,
    output logic               done
);

    import onehot_pkg::*;

    state_t             state_r;
    logic [N_LINES-1:0] pending_r;

    logic [N_LINES-1:0] clr_vec_s;
    logic [N_LINES-1:0] find_vec_s;
    logic [CODE_W-1:0]  find_idx_s;
    logic               find_any_s;
    logic [CODE_W-1:0]  next_code_s;
    logic [CODE_W-1:0]  load_cnt_s;

    // In IDLE the finder looks at the incoming vector; in EMIT at pending minus its lowest bit,
    // so find_any_s low there means the current code is the last one
    always_comb begin
        clr_vec_s   = pending_r & (pending_r - N_LINES'(1));
        find_vec_s  = (state_r == IDLE) ? req_vec : clr_vec_s;
        next_code_s = find_idx_s + CODE_W'(1);
    end

    onehot_lsb_find #(
        .W     (N_LINES),
        .IDX_W (CODE_W)
    ) u_lsb_find (
        .vec (find_vec_s),
        .idx (find_idx_s),
        .any (find_any_s)
    );

    // Number of codes a load will produce
    always_comb begin
        load_cnt_s = {CODE_W{1'b0}};
        for (int i = 0; i < N_LINES; i++) begin
            load_cnt_s = load_cnt_s + CODE_W'(req_vec[i]);
        end
    end

    // Sequencer FSM with pending mask, remaining counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pending_r  <= {N_LINES{1'b0}};
            code_out   <= CODE_W'(NONE_CODE);
            code_valid <= 1'b0;
            remaining  <= {CODE_W{1'b0}};
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_load) begin
                        pending_r <= req_vec;
                        remaining <= load_cnt_s;
                        if (find_any_s) begin
                            state_r    <= EMIT;
                            code_valid <= 1'b1;
                            code_out   <= next_code_s;
                            load_ready <= 1'b0;
                        end else begin
`ifdef ONEHOT_EMPTY_CODE_EN
                            state_r    <= EMIT;
                            code_valid <= 1'b1;
                            code_out   <= CODE_W'(NONE_CODE);
                            remaining  <= CODE_W'(1);
                            load_ready <= 1'b0;
`else
                            done       <= 1'b1;
`endif
                        end
                    end
                end
                EMIT: begin
                    // code_valid is always high here, so ready alone completes the handshake
                    if (code_ready) begin
                        pending_r <= clr_vec_s;
                        remaining <= remaining - CODE_W'(1);
                        if (find_any_s) begin
                            code_out <= next_code_s;
                        end else begin
                            state_r    <= IDLE;
                            code_valid <= 1'b0;
                            code_out   <= CODE_W'(NONE_CODE);
                            load_ready <= 1'b1;
                            done       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    pending_r  <= {N_LINES{1'b0}};
                    code_out   <= CODE_W'(NONE_CODE);
                    code_valid <= 1'b0;
                    remaining  <= {CODE_W{1'b0}};
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_to_binary_sequencer.sv
// Self-checking bench for onehot_to_binary_sequencer: table of load vectors with
// backpressure patterns, a scoreboard of expected codes, and a hand-written reset sequence.
`timescale 1ns/1ps
module tb_onehot_to_binary_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] req_vec;
    logic        req_load;
    logic        load_ready;
    logic [4:0]  code_out;
    logic        code_valid;
    logic        code_ready;
    logic [4:0]  remaining;
    logic        done;

    onehot_to_binary_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_vec    (req_vec),
        .req_load   (req_load),
        .load_ready (load_ready),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .remaining  (remaining),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] code;
        logic [4:0] rem;
    } beat_t;

    typedef struct {
        logic [19:0] vec;
        logic [63:0] stall;
        bit          poke;
        int          exp_beats;
    } vec_t;

`ifdef ONEHOT_EMPTY_CODE_EN
    localparam int EMPTY_BEATS = 1;
`else
    localparam int EMPTY_BEATS = 0;
`endif

    beat_t exp_q[$];
    vec_t  tbl[6];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one beat per set bit, ascending, with the count still to deliver
    function automatic void build_expect(input logic [19:0] vec);
        int n;
        int left;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (vec[k]) n++;
        end
        left = n;
        for (int k = 0; k < 20; k++) begin
            if (vec[k]) begin
                exp_q.push_back('{code: 5'(k + 1), rem: 5'(left)});
                left--;
            end
        end
`ifdef ONEHOT_EMPTY_CODE_EN
        if (n == 0) exp_q.push_back('{code: 5'd0, rem: 5'd1});
`endif
    endfunction

    task automatic run_load(input vec_t t, input int idx);
        int cyc;
        int beats;
        bit done_pend;
        bit done_seen;
        build_expect(t.vec);
        done_pend  = (exp_q.size() == 0);
        done_seen  = 1'b0;
        beats      = 0;
        cyc        = 0;
        req_vec    = t.vec;
        req_load   = 1'b1;
        code_ready = ~t.stall[0];
        @(posedge clk);
        #1;
        req_load = 1'b0;
        req_vec  = 20'h00000;
        while (!done_seen && cyc < 100) begin
            @(negedge clk);
            if (done_pend) begin
                check("done_pulse", {31'd0, done}, 32'd1);
                check("done_load_ready", {31'd0, load_ready}, 32'd1);
                check("done_valid_low", {31'd0, code_valid}, 32'd0);
                check("done_code_zero", {27'd0, code_out}, 32'd0);
                done_seen = 1'b1;
            end else begin
                check("no_early_done", {31'd0, done}, 32'd0);
                check("valid_high", {31'd0, code_valid}, 32'd1);
                check("load_ready_low", {31'd0, load_ready}, 32'd0);
                check("code", {27'd0, code_out}, {27'd0, exp_q[0].code});
                check("remaining", {27'd0, remaining}, {27'd0, exp_q[0].rem});
                if (code_ready && code_valid) begin
                    void'(exp_q.pop_front());
                    beats++;
                    if (exp_q.size() == 0) done_pend = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            code_ready = (cyc < 64) ? ~t.stall[cyc] : 1'b1;
            req_load   = t.poke && (cyc == 1);
            req_vec    = (t.poke && cyc == 1) ? 20'h00001 : 20'h00000;
        end
        check("no_timeout", {31'd0, done_seen}, 32'd1);
        check("beats", beats, t.exp_beats);
        exp_q.delete();
        req_load = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_load_ready", {31'd0, load_ready}, 32'd1);
        if (errors != 0) $display("  after vector %0d (%h)", idx, t.vec);
    endtask

    initial begin
        tbl[0] = '{vec: 20'h00005, stall: 64'h0, poke: 1'b0, exp_beats: 2};
        tbl[1] = '{vec: 20'h80000, stall: 64'h7, poke: 1'b0, exp_beats: 1};
        tbl[2] = '{vec: 20'hFFFFF, stall: 64'h0, poke: 1'b0, exp_beats: 20};
        tbl[3] = '{vec: 20'h00000, stall: 64'h0, poke: 1'b0, exp_beats: EMPTY_BEATS};
        tbl[4] = '{vec: 20'h00012, stall: 64'h1, poke: 1'b1, exp_beats: 2};
        tbl[5] = '{vec: 20'hA5A5A, stall: 64'h0000_0000_0000_0A52, poke: 1'b0, exp_beats: 10};

        rst        = 1'b1;
        req_vec    = 20'h00000;
        req_load   = 1'b0;
        code_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_load_ready", {31'd0, load_ready}, 32'd1);
        check("rst_valid", {31'd0, code_valid}, 32'd0);
        check("rst_code", {27'd0, code_out}, 32'd0);
        check("rst_remaining", {27'd0, remaining}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_load(tbl[i], i);
        end

        // Reset in the middle of a burst discards the rest without a done pulse
        @(posedge clk);
        #1;
        req_vec    = 20'h000F0;
        req_load   = 1'b1;
        code_ready = 1'b1;
        @(posedge clk);
        #1;
        req_load = 1'b0;
        req_vec  = 20'h00000;
        @(negedge clk);
        check("mid_code0", {27'd0, code_out}, 32'd5);
        check("mid_rem0", {27'd0, remaining}, 32'd4);
        @(negedge clk);
        check("mid_code1", {27'd0, code_out}, 32'd6);
        check("mid_rem1", {27'd0, remaining}, 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_code2", {27'd0, code_out}, 32'd7);
        check("mid_rem2", {27'd0, remaining}, 32'd2);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        code_ready = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {31'd0, code_valid}, 32'd0);
        check("post_rst_remaining", {27'd0, remaining}, 32'd0);
        check("post_rst_code", {27'd0, code_out}, 32'd0);
        check("post_rst_load_ready", {31'd0, load_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
